// File: rtl/fp_add_accum.sv
// Accumulating front-end for the pipelined FP adder: sums an operand
// stream, tracks sticky flags and returns the total on a result port.
module fp_add_accum #(
    parameter int W   = 32,
    parameter int LAT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    input  logic [2:0]   round_m,
    output logic [W-1:0] add_in1,
    output logic [W-1:0] add_in2,
    output logic [2:0]   add_round_m,
    output logic         add_act,
    input  logic [W-1:0] add_out,
    input  logic         add_ov,
    input  logic         add_un,
    input  logic         add_inv,
    input  logic         add_inexact,
    input  logic         add_done,
    output logic [W-1:0] res_data,
    output logic         res_ov,
    output logic         res_un,
    output logic         res_inv,
    output logic         res_inexact,
    output logic [15:0]  res_cnt,
    output logic         res_valid,
    input  logic         res_ready
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    logic [1:0]   state;
    logic [W-1:0] acc;
    logic [W-1:0] op;
    logic [2:0]   rm;
    logic         last;
    logic [2:0]   wcnt;
    logic         act;
    logic [15:0]  cnt;
    logic         f_ov;
    logic         f_un;
    logic         f_inv;
    logic         f_ix;
    logic         accept;

    // Gate with reset so the port reads 0 while the block is held.
    assign in_ready = rst & ((state == S_IDLE) | (state == S_ACC));
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            acc   <= '0;
            op    <= '0;
            rm    <= '0;
            last  <= 1'b0;
            wcnt  <= '0;
            act   <= 1'b0;
            cnt   <= '0;
            f_ov  <= 1'b0;
            f_un  <= 1'b0;
            f_inv <= 1'b0;
            f_ix  <= 1'b0;
        end else begin
            act <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        acc   <= in_data;
                        rm    <= round_m;
                        cnt   <= 16'd1;
                        f_ov  <= 1'b0;
                        f_un  <= 1'b0;
                        f_inv <= 1'b0;
                        f_ix  <= 1'b0;
                        state <= in_last ? S_OUT : S_ACC;
                    end
                end
                S_ACC: begin
                    if (accept) begin
                        op    <= in_data;
                        last  <= in_last;
                        wcnt  <= 3'(LAT);
                        act   <= 1'b1;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wcnt != 3'd0) begin
                        wcnt <= wcnt - 3'd1;
                    end else if (add_done) begin
                        acc   <= add_out;
                        f_ov  <= f_ov | add_ov;
                        f_un  <= f_un | add_un;
                        f_inv <= f_inv | add_inv;
                        f_ix  <= f_ix | add_inexact;
                        if (cnt != 16'hFFFF)
                            cnt <= cnt + 16'd1;
                        state <= last ? S_OUT : S_ACC;
                    end
                end
                S_OUT: begin
                    if (res_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign add_in1     = acc;
    assign add_in2     = op;
    assign add_round_m = rm;
    assign add_act     = act;
    assign res_data    = acc;
    assign res_ov      = f_ov;
    assign res_un      = f_un;
    assign res_inv     = f_inv;
    assign res_inexact = f_ix;
    assign res_cnt     = cnt;
    assign res_valid   = (state == S_OUT);

endmodule

// File: tb/tb_fp_add_accum.sv
// Bench for fp_add_accum with a behavioural FP adder stub and a
// sequence-level reference model of the accumulated sum and flags.
module tb_fp_add_accum;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [2:0]  round_m;
    logic [31:0] add_in1;
    logic [31:0] add_in2;
    logic [2:0]  add_round_m;
    logic        add_act;
    logic [31:0] add_out;
    logic        add_ov;
    logic        add_un;
    logic        add_inv;
    logic        add_inexact;
    logic        add_done;
    logic [31:0] res_data;
    logic        res_ov;
    logic        res_un;
    logic        res_inv;
    logic        res_inexact;
    logic [15:0] res_cnt;
    logic        res_valid;
    logic        res_ready;

    always #5 clk = ~clk;

    fp_add_accum #(.W(32), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .round_m(round_m),
        .add_in1(add_in1), .add_in2(add_in2),
        .add_round_m(add_round_m), .add_act(add_act),
        .add_out(add_out), .add_ov(add_ov), .add_un(add_un),
        .add_inv(add_inv), .add_inexact(add_inexact),
        .add_done(add_done),
        .res_data(res_data), .res_ov(res_ov), .res_un(res_un),
        .res_inv(res_inv), .res_inexact(res_inexact),
        .res_cnt(res_cnt), .res_valid(res_valid),
        .res_ready(res_ready)
    );

    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    int acts = 0;
    int stall = 0;
    logic [2:0] seq_rm = 3'd0;
    logic [31:0] elems[$];
    int acc_t[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic real f2r(input logic [31:0] b);
        real r;
        int e;
        e = int'(b[30:23]);
        if (e == 0) return 0.0;
        r = 1.0 + real'(b[22:0]) / 8388608.0;
        if (e > 127) repeat (e - 127) r = r * 2.0;
        else repeat (127 - e) r = r / 2.0;
        return b[31] ? -r : r;
    endfunction

    // Truncating single-precision add; IEEE specials, ov/un/inexact.
    task automatic fadd(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] s, output logic [3:0] f);
        logic an, bn, ai, bi, sg;
        real r, v, fr;
        int e, m;
        an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        f = 4'b0;
        s = 32'h0;
        if (an || bn) s = 32'h7FC00000;
        else if (ai && bi && (a[31] != b[31])) begin
            s = 32'h7FC00000;
            f[1] = 1'b1;
        end else if (ai) s = a;
        else if (bi) s = b;
        else begin
            r = f2r(a) + f2r(b);
            if (r != 0.0) begin
                sg = (r < 0.0);
                v = sg ? -r : r;
                e = 127;
                while (v >= 2.0 && e < 255) begin v = v / 2.0; e++; end
                while (v < 1.0 && e > 0) begin v = v * 2.0; e--; end
                if (e >= 255) begin
                    s = {sg, 8'hFF, 23'd0};
                    f[3] = 1'b1;
                    f[0] = 1'b1;
                end else if (e == 0) begin
                    s = {sg, 31'd0};
                    f[2] = 1'b1;
                    f[0] = 1'b1;
                end else begin
                    fr = (v - 1.0) * 8388608.0;
                    m = $rtoi(fr);
                    f[0] = (real'(m) != fr);
                    s = {sg, e[7:0], m[22:0]};
                end
            end
        end
    endtask

    // Reference: fold the adder over the sequence, OR flags, count.
    task automatic model(output logic [31:0] s, output logic [3:0] f,
                         output logic [15:0] c);
        logic [31:0] t;
        logic [3:0] tf;
        s = elems[0];
        f = 4'b0;
        c = 16'd1;
        for (int i = 1; i < elems.size(); i++) begin
            fadd(s, elems[i], t, tf);
            s = t;
            f = f | tf;
            c = (c == 16'hFFFF) ? c : c + 16'd1;
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (add_act) acts <= acts + 1;
    end

    // Adder stub: result and done appear LAT+stall edges after the strobe.
    logic [31:0] p_out;
    logic [3:0]  p_f;
    logic [31:0] t_out;
    logic [3:0]  t_f;
    int pend = 0;
    always @(posedge clk) begin
        if (!rst) begin
            add_done <= 1'b0;
            add_out <= 32'h0;
            {add_ov, add_un, add_inv, add_inexact} <= 4'b0;
            pend <= 0;
        end else if (add_act) begin
            fadd(add_in1, add_in2, t_out, t_f);
            check("add_rm", 32'(add_round_m), 32'(seq_rm));
            p_out <= t_out;
            p_f <= t_f;
            add_done <= 1'b0;
            if (LAT - 1 + stall == 0) begin
                add_done <= 1'b1;
                add_out <= t_out;
                {add_ov, add_un, add_inv, add_inexact} <= t_f;
                pend <= 0;
            end else begin
                pend <= LAT - 1 + stall;
            end
        end else if (pend == 1) begin
            add_done <= 1'b1;
            add_out <= p_out;
            {add_ov, add_un, add_inv, add_inexact} <= p_f;
            pend <= 0;
        end else if (pend > 1) begin
            pend <= pend - 1;
        end
    end

    task automatic push(input logic [31:0] d, input logic l,
                        input logic [2:0] rm, output int t);
        int n;
        in_data = d;
        in_last = l;
        round_m = rm;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) check("accept_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        t = cyc;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic run_seq(input int hold, input bit vin);
        logic [31:0] ed;
        logic [3:0] ef;
        logic [15:0] ec;
        int a0, n, tl, el;
        model(ed, ef, ec);
        a0 = acts;
        acc_t.delete();
        tl = 0;
        for (int i = 0; i < elems.size(); i++) begin
            push(elems[i], i == elems.size() - 1,
                 (i == 0) ? seq_rm : 3'($urandom_range(0, 7)), tl);
            acc_t.push_back(tl);
        end
        n = 0;
        while (!res_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!res_valid) check("res_timeout", 32'd1, 32'd0);
        el = (elems.size() > 1) ? LAT + 1 + stall : 0;
        check("cap_lat", cyc - tl, el);
        check("data", res_data, ed);
        check("flags", 32'({res_ov, res_un, res_inv, res_inexact}), 32'(ef));
        check("cnt", 32'(res_cnt), 32'(ec));
        check("act_pulses", acts - a0, elems.size() - 1);
        if (vin) begin
            in_data = 32'h3F800000;
            in_last = 1'b1;
            in_valid = 1'b1;
        end
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            check("hold_rdy", 32'(in_ready), 32'd0);
            check("hold_vld", 32'(res_valid), 32'd1);
            check("hold_data", res_data, ed);
            check("hold_cnt", 32'(res_cnt), 32'(ec));
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check("post_vld", 32'(res_valid), 32'd0);
        check("post_rdy", 32'(in_ready), 32'd1);
    endtask

    function automatic logic [31:0] rnd_fp();
        logic [31:0] sp[3];
        sp[0] = 32'h7F800000;
        sp[1] = 32'hFF800000;
        sp[2] = 32'h7FC00000;
        if ($urandom_range(0, 15) == 0) return sp[$urandom_range(0, 2)];
        return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)),
                23'($urandom)};
    endfunction

    initial begin
        rst = 1'b0;
        in_data = 32'h0;
        in_valid = 1'b0;
        in_last = 1'b0;
        round_m = 3'd0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", 32'(in_ready), 32'd0);
        check("rst_act", 32'(add_act), 32'd0);
        check("rst_vld", 32'(res_valid), 32'd0);
        check("rst_data", res_data, 32'h0);
        check("rst_cnt", 32'(res_cnt), 32'd0);
        check("rst_in1", add_in1, 32'h0);
        check("rst_flags",
              32'({res_ov, res_un, res_inv, res_inexact}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rel_rdy", 32'(in_ready), 32'd1);

        elems = '{32'h3F800000, 32'h40000000};
        seq_rm = 3'd0;
        run_seq(0, 0);

        elems = '{32'h3F800000};
        run_seq(0, 0);

        elems = '{32'h7F800000, 32'hFF800000, 32'h3F800000};
        seq_rm = 3'd3;
        in_valid = 1'b1;
        run_seq(0, 0);
        check("interval", acc_t[2] - acc_t[1], LAT + 2);

        elems = '{32'h3F800000, 32'h3F800000};
        seq_rm = 3'd1;
        run_seq(5, 1);
        elems = '{32'h3F800000};
        run_seq(0, 0);

        seq_rm = 3'd2;
        begin
            int t;
            push(32'h3F800000, 1'b0, seq_rm, t);
            push(32'h40000000, 1'b1, 3'd5, t);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("mid_act", 32'(add_act), 32'd0);
        check("mid_vld", 32'(res_valid), 32'd0);
        check("mid_cnt", 32'(res_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rdy", 32'(in_ready), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("mid_quiet", 32'(res_valid), 32'd0);
        elems = '{32'h3F000000, 32'h3F000000};
        run_seq(0, 0);

        stall = 3;
        elems = '{32'h3F800000, 32'h40000000};
        run_seq(0, 0);

        for (int s = 0; s < 25; s++) begin
            elems.delete();
            for (int i = 0; i < $urandom_range(1, 6); i++)
                elems.push_back(rnd_fp());
            if (elems.size() == 0) elems.push_back(rnd_fp());
            seq_rm = 3'($urandom_range(0, 7));
            stall = $urandom_range(0, 2);
            run_seq($urandom_range(0, 3), 0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/fp_add_accum.md
# fp_add_accum

Sequencing front-end that sums a stream of single-precision operands by repeatedly driving the team's 32-bit pipelined FP adder as its initiator. It accepts operands over a valid/ready stream terminated by `in_last`, issues `acc + x` to the adder, and captures each result after the adder's fixed latency. It accumulates sticky exception flags and presents the final sum and flags over a valid/ready result port. It sits between the FPU command path and the adder instance, which is external to this block.

## Interface
- `W`, 32 — operand/result width (IEEE-754 single)
- `LAT`, 2 — adder latency in clocks from operand presentation to registered `add_out`; legal 1..7
- `clk` in 1 — clock, all state on rising edge
- `rst` in 1 — asynchronous, active-low reset
- `in_data` in W — operand
- `in_valid` in 1 — operand valid
- `in_last` in 1 — operand is final element of the sequence
- `in_ready` out 1 — block can accept an operand
- `round_m` in 3 — rounding mode, sampled with first element of a sequence
- `add_in1`, `add_in2` out W — operands to adder (accumulator, new element)
- `add_round_m` out 3 — rounding mode to adder
- `add_act` out 1 — one-cycle issue strobe to adder
- `add_out` in W — adder result
- `add_ov`, `add_un`, `add_inv`, `add_inexact`, `add_done` in 1 — adder flags/done
- `res_data` out W — final sum
- `res_ov`, `res_un`, `res_inv`, `res_inexact` out 1 — sticky flags of the sequence
- `res_cnt` out 16 — elements summed, saturating at 0xFFFF
- `res_valid` out 1 — result valid
- `res_ready` in 1 — result consumer ready

## Operation
- States: IDLE, ACC, WAIT, OUT.
- IDLE: `in_ready`=1. On `in_valid&in_ready`: acc←`in_data` directly (no add issued; avoids zero-operand path in adder), rm←`round_m`, cnt←1, flags←0; → OUT if `in_last`, else → ACC.
- ACC: `in_ready`=1. On accept: op←`in_data`, last←`in_last`, wait counter←LAT, `add_act`←1 for exactly one cycle; → WAIT.
- WAIT: `in_ready`=0. `add_in1`=acc, `add_in2`=op, `add_round_m`=rm held stable for the entire state (adder uses inputs combinationally in both stages). Counter decrements each cycle; when counter=0 and `add_done`=1: acc←`add_out`, each sticky flag ←flag | corresponding `add_*`, cnt←sat(cnt+1); → OUT if last, else → ACC. If `add_done`=0 at counter 0, remain in WAIT until it rises.
- OUT: `res_valid`=1, `res_data`=acc, flags and cnt presented, `in_ready`=0; all stable until `res_valid&res_ready`, then → IDLE.
- Sequence continues after `res_inv`/`res_ov` set; flags only OR in, never clear mid-sequence.
- `in_last` ignored unless `in_valid&in_ready`.
- `round_m` changes mid-sequence have no effect.

## Timing
- Reset values: state IDLE, `in_ready`=0 during reset, 1 in first cycle after release; `add_act`=0, `add_in1`=`add_in2`=0, `add_round_m`=0, `res_valid`=0, `res_data`=0, all `res_*` flags 0, `res_cnt`=0.
- Element accepted at edge t in ACC: `add_act`=1 in cycle t..t+1; result captured at edge t+LAT+1; `in_ready` high again after that edge; next accept earliest edge t+LAT+2 (LAT=2: one element per 4 clocks).
- Single-element sequence: accept at edge t, `res_valid`=1 after edge t.
- Last element captured at edge c: `res_valid`=1 after edge c. Handshake at edge h: `res_valid`=0 and `in_ready`=1 after h.
- Reset asserted in any state: immediate return to reset values; any in-flight adder result is discarded.
- `res_cnt` saturates at 0xFFFF; no wrap.

## Test plan
- 0x3F800000 (1.0), 0x40000000 (2.0, last), RNe -> one `add_act` pulse, `res_data`=0x40400000, all flags 0, `res_cnt`=2, capture exactly LAT+1 edges after second accept.
- Single 0x3F800000 with `in_last` -> `add_act` never asserted, `res_data`=0x3F800000, `res_cnt`=1, `res_valid` one cycle after accept.
- 0x7F800000, 0xFF800000, 0x3F800000 (last) -> `res_inv`=1 sticky after the third element, `res_cnt`=3, `res_data` equals the adder's second returned value.
- `res_ready` held low 5 cycles with `in_valid` high -> `res_data`/flags stable, `in_ready`=0 throughout, accept only after handshake.
- Rst low during WAIT of element 2 -> `add_act`=0, `res_valid`=0, state IDLE; fresh 0x3F000000+0x3F000000 sequence then gives 0x3F800000, `res_cnt`=2.
- `add_done` held low 3 extra cycles at counter 0 -> capture delayed 3 cycles, result unchanged.
